bip_fetch_ctrl: RTL and testbench

- Instruction-fetch and control unit of the BIP core; sits directly upstream of the program memory.
- Drives the program-memory address from an internal PC and consumes the 16-bit instruction that the memory returns one clock later (synchronous read).
- Decodes opcode[15:11] and operand[10:0] into datapath controls for the accumulator, ALU and data RAM.
- Two-state fetch/execute sequencing gives CPI = 2, plus a terminal HALT state.

---
 rtl/bip_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_bip_fetch_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bip_fetch_ctrl.sv
// BIP instruction-fetch and control unit: two-cycle fetch/execute sequencing plus a terminal HALT.
// Optional macro BIP_CYCLE_COUNT_EN adds a 32-bit free-running cycle counter output.
module bip_fetch_ctrl #(
  parameter int len_addr   = 11,
  parameter int len_data   = 16,
  parameter int len_opcode = 5
) (
  input  logic                clk,
  input  logic                rst,
  output logic [len_addr-1:0] ProgAddr,
  input  logic [len_data-1:0] InstrData,
  output logic [len_addr-1:0] Operand,
  output logic [1:0]          SelA,
  output logic                SelB,
  output logic                Op,
  output logic                WrAcc,
  output logic                WrRam,
  output logic                RdRam,
  output logic                InstrValid,
  output logic                Halted
`ifdef BIP_CYCLE_COUNT_EN
  ,
  output logic [31:0]         CycleCount
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [len_opcode-1:0] OpHlt  = len_opcode'(0);
  localparam logic [len_opcode-1:0] OpSto  = len_opcode'(1);
  localparam logic [len_opcode-1:0] OpLd   = len_opcode'(2);
  localparam logic [len_opcode-1:0] OpLdi  = len_opcode'(3);
  localparam logic [len_opcode-1:0] OpAdd  = len_opcode'(4);
  localparam logic [len_opcode-1:0] OpAddi = len_opcode'(5);
  localparam logic [len_opcode-1:0] OpSub  = len_opcode'(6);
  localparam logic [len_opcode-1:0] OpSubi = len_opcode'(7);

  state_e                state_q, state_d;
  logic [len_addr-1:0]   pc_q, pc_d;
  logic [len_opcode-1:0] opcode;

  assign opcode = InstrData[len_data-1 -: len_opcode];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // HLT leaves the PC on its own address so ProgAddr stays frozen there.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        if (opcode == OpHlt) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          pc_d    = pc_q + len_addr'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Controls derive from the current state only, so an async reset kills any write enable at once.
  always_comb begin
    Operand    = '0;
    SelA       = 2'b00;
    SelB       = 1'b0;
    Op         = 1'b0;
    WrAcc      = 1'b0;
    WrRam      = 1'b0;
    RdRam      = 1'b0;
    InstrValid = 1'b0;
    if (state_q == EXEC) begin
      InstrValid = 1'b1;
      Operand    = InstrData[len_addr-1:0];
      case (opcode)
        OpSto: WrRam = 1'b1;
        OpLd: begin
          RdRam = 1'b1;
          WrAcc = 1'b1;
        end
        OpLdi: begin
          SelA  = 2'b01;
          WrAcc = 1'b1;
        end
        OpAdd: begin
          RdRam = 1'b1;
          SelA  = 2'b10;
          WrAcc = 1'b1;
        end
        OpAddi: begin
          SelB  = 1'b1;
          SelA  = 2'b10;
          WrAcc = 1'b1;
        end
        OpSub: begin
          RdRam = 1'b1;
          Op    = 1'b1;
          SelA  = 2'b10;
          WrAcc = 1'b1;
        end
        OpSubi: begin
          SelB  = 1'b1;
          Op    = 1'b1;
          SelA  = 2'b10;
          WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ProgAddr = pc_q;
  assign Halted   = (state_q == HALT);

`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cnt_q;

  // Counts the edge that enters HALT too, then freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q != HALT) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign CycleCount = cnt_q;
`endif

endmodule

// File: tb/tb_bip_fetch_ctrl.sv
// Scoreboard bench for bip_fetch_ctrl: directed programs push expected EXEC-cycle records,
// a negedge monitor pops and compares them whenever InstrValid is high.
module tb_bip_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] ProgAddr;
  logic [15:0] InstrData;
  logic [10:0] Operand;
  logic [1:0]  SelA;
  logic        SelB, Op, WrAcc, WrRam, RdRam, InstrValid, Halted;
`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] CycleCount;
`endif

  logic [15:0] mem [0:2047];

  typedef struct packed {
    logic [10:0] addr;
    logic [10:0] operand;
    logic [6:0]  ctrl;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // ctrl packing: {SelA[1:0], SelB, Op, WrAcc, WrRam, RdRam}
  localparam logic [6:0] CtlNone = 7'b00_0_0_0_0_0;
  localparam logic [6:0] CtlSto  = 7'b00_0_0_0_1_0;
  localparam logic [6:0] CtlLd   = 7'b00_0_0_1_0_1;
  localparam logic [6:0] CtlLdi  = 7'b01_0_0_1_0_0;
  localparam logic [6:0] CtlAddi = 7'b10_1_0_1_0_0;
  localparam logic [6:0] CtlSub  = 7'b10_0_1_1_0_1;

  bip_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ProgAddr   (ProgAddr),
    .InstrData  (InstrData),
    .Operand    (Operand),
    .SelA       (SelA),
    .SelB       (SelB),
    .Op         (Op),
    .WrAcc      (WrAcc),
    .WrRam      (WrRam),
    .RdRam      (RdRam),
    .InstrValid (InstrValid),
    .Halted     (Halted)
`ifdef BIP_CYCLE_COUNT_EN
    ,
    .CycleCount (CycleCount)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory
  always @(posedge clk) InstrData <= mem[ProgAddr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] addr, input logic [15:0] instr,
                               input logic [10:0] operand, input logic [6:0] ctrl);
    mem[addr] = instr;
    expQ.push_back('{addr: addr, operand: operand, ctrl: ctrl});
  endtask

  task automatic stepNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic startReset();
    rst = 1'b1;
    expQ.delete();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  task automatic releaseReset();
    stepNeg();
    stepNeg();
    rst = 1'b0;
  endtask

  task automatic waitHalt(input string name);
    int n = 0;
    while (!Halted && n < 200) begin
      stepNeg();
      n++;
    end
    checkOutput(name, {31'b0, Halted}, 32'd1);
  endtask

  // Monitor: every EXEC cycle must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && InstrValid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected exec: got ProgAddr 0x%0h, expected no instruction", ProgAddr);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("exec addr", {21'b0, ProgAddr}, {21'b0, e.addr});
        checkOutput("exec operand", {21'b0, Operand}, {21'b0, e.operand});
        checkOutput("exec controls", {25'b0, SelA, SelB, Op, WrAcc, WrRam, RdRam}, {25'b0, e.ctrl});
        checkOutput("halted in exec", {31'b0, Halted}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq [7] = '{0, 0, 1, 1, 2, 2, 3};
    int n;

    // Program 1: LDI 5, ADDI 3, STO 7, HLT
    startReset();
    applyStimulus(11'd0, 16'h1805, 11'd5, CtlLdi);
    applyStimulus(11'd1, 16'h2803, 11'd3, CtlAddi);
    applyStimulus(11'd2, 16'h0807, 11'd7, CtlSto);
    applyStimulus(11'd3, 16'h0000, 11'd0, CtlNone);
    stepNeg();
    checkOutput("reset ProgAddr", {21'b0, ProgAddr}, 32'd0);
    checkOutput("reset Operand", {21'b0, Operand}, 32'd0);
    checkOutput("reset controls", {25'b0, SelA, SelB, Op, WrAcc, WrRam, RdRam}, 32'd0);
    checkOutput("reset InstrValid", {31'b0, InstrValid}, 32'd0);
    checkOutput("reset Halted", {31'b0, Halted}, 32'd0);
    releaseReset();
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("addr seq %0d", i), {21'b0, ProgAddr}, seq[i]);
      stepNeg();
    end
    waitHalt("program 1 halts");
    checkOutput("halt ProgAddr", {21'b0, ProgAddr}, 32'd3);
    checkOutput("halt InstrValid", {31'b0, InstrValid}, 32'd0);
`ifdef BIP_CYCLE_COUNT_EN
    checkOutput("halt CycleCount", CycleCount, 32'd8);
`endif
    for (int i = 0; i < 20; i++) stepNeg();
    checkOutput("frozen ProgAddr", {21'b0, ProgAddr}, 32'd3);
    checkOutput("frozen Halted", {31'b0, Halted}, 32'd1);
    checkOutput("frozen controls", {25'b0, SelA, SelB, Op, WrAcc, WrRam, RdRam}, 32'd0);
`ifdef BIP_CYCLE_COUNT_EN
    checkOutput("frozen CycleCount", CycleCount, 32'd8);
`endif
    checkOutput("program 1 drained", expQ.size(), 32'd0);

    // Program 2: LD 4, SUB 2, HLT
    startReset();
    applyStimulus(11'd0, 16'h1004, 11'd4, CtlLd);
    applyStimulus(11'd1, 16'h3002, 11'd2, CtlSub);
    applyStimulus(11'd2, 16'h0000, 11'd0, CtlNone);
    releaseReset();
    waitHalt("program 2 halts");
    checkOutput("program 2 drained", expQ.size(), 32'd0);

    // Program 3: top-opcode NOP then HLT
    startReset();
    applyStimulus(11'd0, 16'hF800, 11'd0, CtlNone);
    applyStimulus(11'd1, 16'h0000, 11'd0, CtlNone);
    releaseReset();
    waitHalt("program 3 halts");
    checkOutput("program 3 halt addr", {21'b0, ProgAddr}, 32'd1);

    // Program 4: NOPs everywhere, PC must wrap 2047 -> 0
    startReset();
    for (int i = 0; i < 2048; i++) applyStimulus(11'(i), {5'b01000, 11'(i)}, 11'(i), CtlNone);
    expQ.push_back('{addr: 11'd0, operand: 11'd0, ctrl: CtlNone});
    releaseReset();
    n = 0;
    while (expQ.size() != 0 && n < 4300) begin
      stepNeg();
      n++;
    end
    checkOutput("wrap drained", expQ.size(), 32'd0);
    checkOutput("wrap ProgAddr", {21'b0, ProgAddr}, 32'd0);
    checkOutput("wrap no halt", {31'b0, Halted}, 32'd0);

    // Program 5: reset asserted while STO is executing
    startReset();
    applyStimulus(11'd0, 16'h0807, 11'd7, CtlSto);
    releaseReset();
    stepNeg();
    checkOutput("STO WrRam before reset", {31'b0, WrRam}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("WrRam drops on reset", {31'b0, WrRam}, 32'd0);
    checkOutput("InstrValid drops on reset", {31'b0, InstrValid}, 32'd0);
    checkOutput("ProgAddr on reset", {21'b0, ProgAddr}, 32'd0);
    applyStimulus(11'd0, 16'h0807, 11'd7, CtlSto);
    applyStimulus(11'd1, 16'h0000, 11'd0, CtlNone);
    stepNeg();
    rst = 1'b0;
    checkOutput("post-reset ProgAddr", {21'b0, ProgAddr}, 32'd0);
    checkOutput("post-reset Halted", {31'b0, Halted}, 32'd0);
    waitHalt("program 5 halts");
    checkOutput("program 5 drained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
